branch_ctrl: RTL and testbench

Branch sequencing controller for the ARM core. It accepts branch/branch-with-link (B/BL) requests from decode and forms the 32-bit target from the 24-bit word offset. It then redirects fetch with a one-cycle PC-load pulse, writes the link register for BL, and holds the pipeline flush for a programmable number of cycles before accepting the next branch. It sits between decode, the PC register/fetch stage and the register-file write port.

---
 rtl/branch_ctrl.sv | 120 ++++++++++++
 tb/tb_branch_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// B/BL sequencing controller: forms the branch target, pulses the PC load and link write, then holds flush.
// Optional taken/not-taken statistics counters are enabled by defining BRANCH_CTRL_STATS_EN.
module branch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [31:0] br_pc,
    input  logic [23:0] br_imm24,
    input  logic        br_link,
    input  logic        br_cond_pass,
    input  logic        kill,
    output logic        pc_load,
    output logic [31:0] pc_target,
    output logic        lr_we,
    output logic [31:0] lr_data,
    output logic        flush,
`ifdef BRANCH_CTRL_STATS_EN
    output logic [15:0] taken_cnt,
    output logic [15:0] nottaken_cnt,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CALC, REDIRECT, FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [23:0] imm_q;
    logic        link_q;
    logic [31:0] target_q;
    logic [31:0] lr_q;
    logic [3:0]  cnt_q;

    logic        accept;
    logic        take;
    logic [31:0] offset;
    logic [31:0] target_d;
    logic [31:0] lr_d;

    // kill blocks acceptance so an aborted cycle never latches a new branch
    assign accept   = (state_q == IDLE) && br_valid && !kill;
    assign take     = accept && br_cond_pass;
    assign offset   = {{6{imm_q[23]}}, imm_q, 2'b00};
    assign target_d = pc_q + 32'd8 + offset;
    assign lr_d     = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            imm_q    <= '0;
            link_q   <= 1'b0;
            target_q <= '0;
            lr_q     <= '0;
            cnt_q    <= '0;
        end else if (kill) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        pc_q    <= br_pc;
                        imm_q   <= br_imm24;
                        link_q  <= br_link;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    target_q <= target_d;
                    lr_q     <= lr_d;
                    state_q  <= REDIRECT;
                end
                REDIRECT: begin
                    cnt_q   <= FLUSH_LOAD;
                    state_q <= FLUSH;
                end
                FLUSH: begin
                    if (cnt_q <= 4'd1) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // kill in the redirect cycle must squash the pulses in that same cycle
    assign pc_load   = (state_q == REDIRECT) && !kill;
    assign lr_we     = (state_q == REDIRECT) && link_q && !kill;
    assign pc_target = target_q;
    assign lr_data   = lr_q;
    assign br_ready  = (state_q == IDLE);
    assign flush     = (state_q != IDLE);
    assign busy      = (state_q != IDLE);

`ifdef BRANCH_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
        end else if (accept) begin
            if (br_cond_pass) begin
                if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
            end else begin
                if (nottaken_cnt != 16'hFFFF) nottaken_cnt <= nottaken_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: table of taken branches plus not-taken, kill and reset sequences.
module tb_branch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic        br_ready;
    logic [31:0] br_pc;
    logic [23:0] br_imm24;
    logic        br_link;
    logic        br_cond_pass;
    logic        kill;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        lr_we;
    logic [31:0] lr_data;
    logic        flush;
    logic        busy;
`ifdef BRANCH_CTRL_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] nottaken_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int exp_taken = 0;
    int exp_nottaken = 0;

    branch_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .br_valid     (br_valid),
        .br_ready     (br_ready),
        .br_pc        (br_pc),
        .br_imm24     (br_imm24),
        .br_link      (br_link),
        .br_cond_pass (br_cond_pass),
        .kill         (kill),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .lr_we        (lr_we),
        .lr_data      (lr_data),
        .flush        (flush),
`ifdef BRANCH_CTRL_STATS_EN
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [23:0] imm;
        logic        link;
        logic [31:0] exp_target;
        logic [31:0] exp_lr;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_taken(input vec_t v, input int idx);
        br_pc        = v.pc;
        br_imm24     = v.imm;
        br_link      = v.link;
        br_cond_pass = 1'b1;
        br_valid     = 1'b1;
        chk($sformatf("v%0d ready_T", idx), {31'b0, br_ready}, 32'd1);
        step();  // T+1: CALC
        br_valid = 1'b0;
        chk($sformatf("v%0d flush_T1", idx), {31'b0, flush}, 32'd1);
        chk($sformatf("v%0d ready_T1", idx), {31'b0, br_ready}, 32'd0);
        chk($sformatf("v%0d pcload_T1", idx), {31'b0, pc_load}, 32'd0);
        step();  // T+2: REDIRECT
        chk($sformatf("v%0d pcload_T2", idx), {31'b0, pc_load}, 32'd1);
        chk($sformatf("v%0d target", idx), pc_target, v.exp_target);
        chk($sformatf("v%0d lrwe_T2", idx), {31'b0, lr_we}, {31'b0, v.link});
        if (v.link) chk($sformatf("v%0d lrdata", idx), lr_data, v.exp_lr);
        step();  // T+3
        chk($sformatf("v%0d pcload_T3", idx), {31'b0, pc_load}, 32'd0);
        chk($sformatf("v%0d flush_T3", idx), {31'b0, flush}, 32'd1);
        step();  // T+4
        chk($sformatf("v%0d flush_T4", idx), {31'b0, flush}, 32'd1);
        chk($sformatf("v%0d ready_T4", idx), {31'b0, br_ready}, 32'd0);
        step();  // T+5
        chk($sformatf("v%0d ready_T5", idx), {31'b0, br_ready}, 32'd1);
        chk($sformatf("v%0d flush_T5", idx), {31'b0, flush}, 32'd0);
        chk($sformatf("v%0d busy_T5", idx), {31'b0, busy}, 32'd0);
        exp_taken++;
        $display("branch %0d pc=0x%08h imm=0x%06h link=%0d target=0x%08h lr=0x%08h",
                 idx, v.pc, v.imm, v.link, pc_target, lr_data);
    endtask

    initial begin
        vecs[0] = '{32'h0000_1000, 24'h000001, 1'b0, 32'h0000_100C, 32'h0000_1004};
        vecs[1] = '{32'h0000_1000, 24'hFFFFFE, 1'b1, 32'h0000_1000, 32'h0000_1004};
        vecs[2] = '{32'hFFFF_FFF8, 24'h000000, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC};
        vecs[3] = '{32'h0000_0000, 24'h800000, 1'b0, 32'hFE00_0008, 32'h0000_0004};
        vecs[4] = '{32'h0040_0000, 24'h7FFFFF, 1'b1, 32'h0240_0004, 32'h0040_0004};

        rst_n = 1'b0; br_valid = 1'b0; br_pc = '0; br_imm24 = '0;
        br_link = 1'b0; br_cond_pass = 1'b0; kill = 1'b0;
        repeat (2) step();
        chk("rst ready",   {31'b0, br_ready}, 32'd1);
        chk("rst pcload",  {31'b0, pc_load}, 32'd0);
        chk("rst lrwe",    {31'b0, lr_we}, 32'd0);
        chk("rst flush",   {31'b0, flush}, 32'd0);
        chk("rst busy",    {31'b0, busy}, 32'd0);
        chk("rst target",  pc_target, 32'd0);
        chk("rst lrdata",  lr_data, 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) run_taken(vecs[i], i);

        // Three back-to-back not-taken branches: accepted every cycle, no penalty
        br_cond_pass = 1'b0;
        br_pc = 32'h0000_2000; br_imm24 = 24'h000010;
        br_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("nt%0d ready", i), {31'b0, br_ready}, 32'd1);
            step();
            chk($sformatf("nt%0d pcload", i), {31'b0, pc_load}, 32'd0);
            chk($sformatf("nt%0d flush", i), {31'b0, flush}, 32'd0);
            exp_nottaken++;
            $display("not-taken %0d flush=%0d ready=%0d", i, flush, br_ready);
        end
        br_valid = 1'b0;
        chk("nt target hold", pc_target, 32'h0240_0004);

        // kill in IDLE with valid: branch not accepted
        br_cond_pass = 1'b1; br_valid = 1'b1; kill = 1'b1;
        step();
        kill = 1'b0; br_valid = 1'b0;
        chk("killidle busy", {31'b0, busy}, 32'd0);
        chk("killidle ready", {31'b0, br_ready}, 32'd1);
        $display("kill in idle busy=%0d", busy);

        // kill in REDIRECT cycle suppresses the pulses
        br_pc = 32'h0000_3000; br_imm24 = 24'h000004; br_link = 1'b1;
        br_cond_pass = 1'b1; br_valid = 1'b1;
        step();  // CALC
        br_valid = 1'b0;
        step();  // REDIRECT
        kill = 1'b1;
        #1;
        chk("killredir pcload", {31'b0, pc_load}, 32'd0);
        chk("killredir lrwe",   {31'b0, lr_we}, 32'd0);
        step();
        kill = 1'b0;
        chk("killredir ready", {31'b0, br_ready}, 32'd1);
        chk("killredir flush", {31'b0, flush}, 32'd0);
        exp_taken++;
        $display("kill in redirect pc_load=%0d ready=%0d", pc_load, br_ready);

        // Reset pulsed during FLUSH
        br_pc = 32'h0000_4000; br_imm24 = 24'h000002; br_link = 1'b1; br_valid = 1'b1;
        step();  // CALC
        br_valid = 1'b0;
        step();  // REDIRECT
        step();  // FLUSH
        chk("pre-rst flush", {31'b0, flush}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst flush",  {31'b0, flush}, 32'd0);
        chk("midrst busy",   {31'b0, busy}, 32'd0);
        chk("midrst ready",  {31'b0, br_ready}, 32'd1);
        chk("midrst target", pc_target, 32'd0);
        chk("midrst lrdata", lr_data, 32'd0);
        exp_taken = 0; exp_nottaken = 0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("postrst pcload%0d", i), {31'b0, pc_load}, 32'd0);
            chk($sformatf("postrst flush%0d", i), {31'b0, flush}, 32'd0);
        end
        $display("reset during flush busy=%0d", busy);

`ifdef BRANCH_CTRL_STATS_EN
        // Stats: two not-taken and one taken after the mid-run reset
        br_cond_pass = 1'b0; br_valid = 1'b1;
        step(); step();
        exp_nottaken += 2;
        br_valid = 1'b0;
        run_taken(vecs[0], 9);
        chk("stats taken",    {16'b0, taken_cnt}, 32'(exp_taken));
        chk("stats nottaken", {16'b0, nottaken_cnt}, 32'(exp_nottaken));
        $display("stats taken=%0d nottaken=%0d", taken_cnt, nottaken_cnt);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
